instr_seq_ctrl: RTL and testbench
=================================

Name: instr_seq_ctrl

Overview:
Fetch/decode/dispatch sequencer for the 16-bit instruction datapath. It fetches instruction words from an instruction memory port using a req/ack handshake and maintains the program counter. Each word is compared against a fixed 16-bit match pattern, default 16'h040B. On a match, the sequencer hands the word to the execute unit over a valid/done handshake. Non-matching words are either skipped or cause a halt, selected by a mode input.

Parameters:
- AW, 8, instruction address width (PC width).
- MATCH_PAT, 16'h040B, instruction pattern that triggers dispatch.
- HALT_PAT, 16'h0000, instruction pattern that forces HALT.

Ports:
- clk, input, 1, single clock; all logic samples on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, pulse that leaves IDLE and begins fetching at start_addr.
- start_addr, input, AW, initial PC, sampled when start is accepted.
- strict, input, 1, 1 = a non-matching, non-halt word forces HALT; 0 = skip it.
- imem_req, output, 1, fetch request; held until imem_ack.
- imem_addr, output, AW, fetch address; equals pc.
- imem_ack, input, 1, memory returns a word this cycle.
- imem_data, input, 16, instruction word, valid when imem_ack=1.
- ex_valid, output, 1, dispatch valid to the execute unit.
- ex_instr, output, 16, dispatched instruction word.
- ex_done, input, 1, execute unit completion.
- busy, output, 1, high in every state except IDLE and HALT.
- halted, output, 1, high in HALT.
- pc, output, AW, current program counter.

Behaviour:
- Reset values: state=IDLE, pc=0, imem_req=0, ex_valid=0, ex_instr=0, busy=0, halted=0. rst wins over every other input in the same cycle; rst during any state aborts the operation with no further outputs.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE:
  - start=1 → pc<=start_addr, go to FETCH.
  - start is ignored in every other state.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1, latch imem_data into ir and go to DECODE.
  - There is no timeout; the FSM waits indefinitely for imem_ack.
- DECODE (exactly 1 cycle), checked in priority order:
  - ir==HALT_PAT → HALT. pc is not incremented.
  - ir==MATCH_PAT → EXEC, with ex_instr<=ir and ex_valid<=1.
  - Otherwise, strict=1 → HALT.
  - Otherwise, strict=0 → pc<=pc+1, go to FETCH.
- EXEC:
  - ex_valid and ex_instr are held stable until ex_done=1.
  - On ex_done: ex_valid<=0, pc<=pc+1, go to FETCH.
  - ex_done sampled outside EXEC is ignored.
- HALT: halted=1, pc frozen; exit only via rst.
- PC arithmetic is modulo 2^AW; wrap from all-ones to 0 is silent and legal.
- Latency:
  - start → first imem_req: 1 cycle.
  - imem_ack → ex_valid: 2 cycles (DECODE, then the EXEC register).
  - ex_done → next imem_req: 1 cycle.
- Match comparison is exact: all 16 bits must be equal, with no don't-care bits.

Optional Feature:
- Macro: INSTR_SEQ_STATS_EN.
- Defined:
  - Adds output ports match_cnt (16-bit) and skip_cnt (16-bit), both reset to 0.
  - match_cnt increments on each DECODE→EXEC transition.
  - skip_cnt increments on each DECODE→FETCH skip.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and the counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package instr_seq_pkg holds:
  - the state enum typedef (IDLE, FETCH, DECODE, EXEC, HALT);
  - the default pattern constants MATCH_PAT_DEF=16'h040B and HALT_PAT_DEF=16'h0000.
- One sub-module, instr_pattern_match: a combinational 16-bit equality matcher (pattern parameter, 1-bit hit output), instantiated twice, once for MATCH_PAT and once for HALT_PAT.

Test Plan:
- rst=1 for 2 cycles, then start=1 with start_addr=8'h10 → imem_req=1 and imem_addr=8'h10 on the next cycle; busy=1.
- Memory returns 16'h040B with a 1-cycle ack → ex_valid=1 and ex_instr=16'h040B 2 cycles after the ack. Hold ex_done=0 for 5 cycles → ex_valid stays high and ex_instr stays stable. Pulse ex_done → next fetch at 8'h11.
- strict=0, memory returns 16'h1234 → no ex_valid, next fetch at pc+1. With strict=1, the same word → halted=1, pc unchanged, imem_req=0.
- Memory returns 16'h0000 → HALT. Further start pulses and ex_done pulses are ignored until rst.
- start_addr=8'hFF, word 16'h040B, ex_done → next fetch at 8'h00 (wrap). rst asserted mid-EXEC → all outputs take their reset values next cycle.
- With INSTR_SEQ_STATS_EN defined: 3 matches and 2 skips → match_cnt=3, skip_cnt=2. With the macro undefined, the bench compiles without the counter ports.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// ---------------------------------------------------------------------------
// instr_seq_pkg
// Shared definitions for the instruction fetch/decode/dispatch sequencer:
//   - state_t       : sequencer FSM state encoding
//   - MATCH_PAT_DEF : default instruction word that triggers dispatch
//   - HALT_PAT_DEF  : default instruction word that forces HALT
//   - CNT_W         : width of the optional statistics counters
// ---------------------------------------------------------------------------
package instr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [15:0] MATCH_PAT_DEF = 16'h040B;
  localparam logic [15:0] HALT_PAT_DEF  = 16'h0000;

  localparam int CNT_W = 16;

endpackage

// File: rtl/instr_pattern_match.sv
// ---------------------------------------------------------------------------
// instr_pattern_match
// Combinational exact 16-bit equality matcher against a fixed pattern.
// Every bit takes part in the compare; there are no don't-care bits.
//
// Parameters:
//   PATTERN - 16-bit word to recognise
// Ports:
//   i_word  - in,  16 : instruction word under test
//   o_hit   - out,  1 : high when i_word equals PATTERN
// ---------------------------------------------------------------------------
module instr_pattern_match
  import instr_seq_pkg::*;
#(
  parameter logic [15:0] PATTERN = MATCH_PAT_DEF
) (
  input  logic [15:0] i_word,
  output logic        o_hit
);

  assign o_hit = (i_word == PATTERN);

endmodule

// File: rtl/instr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// instr_seq_ctrl
// Fetch/decode/dispatch sequencer for the 16-bit instruction datapath.
// Fetches words over a req/ack memory port, keeps the program counter,
// dispatches words equal to MATCH_PAT to the execute unit over a
// valid/done handshake, and skips or halts on anything else depending on
// the strict input. A word equal to HALT_PAT always halts.
//
// Parameters:
//   AW        - program counter / fetch address width
//   MATCH_PAT - instruction word that is dispatched
//   HALT_PAT  - instruction word that forces HALT
//
// Ports:
//   clk        - in,  1  : clock, rising edge
//   rst        - in,  1  : synchronous active-high reset
//   start      - in,  1  : leave IDLE and fetch from start_addr
//   start_addr - in,  AW : initial PC, captured with start
//   strict     - in,  1  : 1 = unknown word halts, 0 = unknown word skipped
//   imem_req   - out, 1  : fetch request, held until imem_ack
//   imem_addr  - out, AW : fetch address (always the PC)
//   imem_ack   - in,  1  : memory word valid this cycle
//   imem_data  - in,  16 : instruction word
//   ex_valid   - out, 1  : dispatch valid, held until ex_done
//   ex_instr   - out, 16 : dispatched instruction word
//   ex_done    - in,  1  : execute unit completion
//   busy       - out, 1  : high outside IDLE and HALT
//   halted     - out, 1  : high in HALT
//   pc         - out, AW : program counter
//   match_cnt  - out, 16 : dispatch count, saturating (INSTR_SEQ_STATS_EN)
//   skip_cnt   - out, 16 : skip count, saturating (INSTR_SEQ_STATS_EN)
//
// Build option: define INSTR_SEQ_STATS_EN to add the match_cnt/skip_cnt
// statistics ports and counters.
// ---------------------------------------------------------------------------
module instr_seq_ctrl
  import instr_seq_pkg::*;
#(
  parameter int          AW        = 8,
  parameter logic [15:0] MATCH_PAT = MATCH_PAT_DEF,
  parameter logic [15:0] HALT_PAT  = HALT_PAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          strict,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_data,
  output logic          ex_valid,
  output logic [15:0]   ex_instr,
  input  logic          ex_done,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] pc
`ifdef INSTR_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] skip_cnt
`endif
);

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic          r_ex_valid;
  logic [15:0]   r_ex_instr;

  logic          w_match_hit;
  logic          w_halt_hit;
  logic          w_in_decode;
  logic          w_to_exec;
  logic          w_to_skip;
  logic [AW-1:0] w_pc_inc;

  instr_pattern_match #(
    .PATTERN (MATCH_PAT)
  ) u_match (
    .i_word (r_ir),
    .o_hit  (w_match_hit)
  );

  instr_pattern_match #(
    .PATTERN (HALT_PAT)
  ) u_halt (
    .i_word (r_ir),
    .o_hit  (w_halt_hit)
  );

  // Decode outcome, in priority order: halt pattern, match, strict halt, skip.
  assign w_in_decode = (r_state == ST_DECODE);
  assign w_to_exec   = w_in_decode && !w_halt_hit && w_match_hit;
  assign w_to_skip   = w_in_decode && !w_halt_hit && !w_match_hit && !strict;

  // Wraps silently from all-ones to zero.
  assign w_pc_inc = r_pc + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ex_valid <= 1'b0;
      r_ex_instr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pc    <= start_addr;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_data;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_halt_hit) begin
            r_state <= ST_HALT;
          end else if (w_match_hit) begin
            r_ex_instr <= r_ir;
            r_ex_valid <= 1'b1;
            r_state    <= ST_EXEC;
          end else if (strict) begin
            r_state <= ST_HALT;
          end else begin
            r_pc    <= w_pc_inc;
            r_state <= ST_FETCH;
          end
        end
        ST_EXEC: begin
          if (ex_done) begin
            r_ex_valid <= 1'b0;
            r_pc       <= w_pc_inc;
            r_state    <= ST_FETCH;
          end
        end
        ST_HALT: begin
          // Terminal until reset; PC stays on the offending word.
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req  = (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign ex_valid  = r_ex_valid;
  assign ex_instr  = r_ex_instr;
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted    = (r_state == ST_HALT);
  assign pc        = r_pc;

`ifdef INSTR_SEQ_STATS_EN
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_skip_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_match_cnt <= '0;
      r_skip_cnt  <= '0;
    end else begin
      if (w_to_exec) begin
        r_match_cnt <= sat_inc(r_match_cnt);
      end
      if (w_to_skip) begin
        r_skip_cnt <= sat_inc(r_skip_cnt);
      end
    end
  end

  assign match_cnt = r_match_cnt;
  assign skip_cnt  = r_skip_cnt;
`endif

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_seq_ctrl
// Directed scenarios followed by randomized programs for instr_seq_ctrl.
// Random programs are predicted by an instruction-level model that walks a
// memory image word by word; the bench plays memory and execute unit with
// random response delays. Counter ports are exercised when the design is
// built with INSTR_SEQ_STATS_EN.
// ---------------------------------------------------------------------------
module tb_instr_seq_ctrl;

  localparam logic [15:0] MATCH_W = 16'h040B;
  localparam logic [15:0] HALT_W  = 16'h0000;
  localparam int          MAXF    = 12;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr;
  logic        strict;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        ex_valid;
  logic [15:0] ex_instr;
  logic        ex_done;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;
`ifdef INSTR_SEQ_STATS_EN
  logic [15:0] match_cnt;
  logic [15:0] skip_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] mem [256];

  instr_seq_ctrl #(.AW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .strict     (strict),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .ex_valid   (ex_valid),
    .ex_instr   (ex_instr),
    .ex_done    (ex_done),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc)
`ifdef INSTR_SEQ_STATS_EN
    ,
    .match_cnt  (match_cnt),
    .skip_cnt   (skip_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    32'(imem_req), 32'(0));
    check({tag, "_valid"},  32'(ex_valid), 32'(0));
    check({tag, "_instr"},  32'(ex_instr), 32'(0));
    check({tag, "_busy"},   32'(busy),     32'(0));
    check({tag, "_halted"}, 32'(halted),   32'(0));
    check({tag, "_pc"},     32'(pc),       32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start      = 1'b0;
  endtask

  // Waits (bounded) for a fetch, then returns word w with a 1-cycle ack.
  task automatic serve(input logic [15:0] w);
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    check("serve_req", 32'(imem_req), 32'(1));
    imem_ack  = 1'b1;
    imem_data = w;
    tick();
    imem_ack  = 1'b0;
    imem_data = 16'($urandom);
  endtask

  task automatic pulse_done();
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
  endtask

  task automatic random_run();
    logic [7:0]  sa;
    logic [7:0]  mpc;
    logic        st;
    logic        exp_halt;
    logic [7:0]  exp_fetch[$];
    logic [15:0] exp_disp[$];
    int          exp_skips;
    int          fi;
    int          di;
    int          ack_wait;
    int          done_wait;
    sa = 8'($urandom);
    st = 1'($urandom_range(0, 1));
    for (int a = 0; a < 256; a++) begin
      int r;
      r = $urandom_range(0, 15);
      mem[a] = (r < 7) ? MATCH_W : (r == 7) ? HALT_W : 16'($urandom);
    end

    // Instruction-level prediction of the run.
    mpc       = sa;
    exp_halt  = 1'b0;
    exp_skips = 0;
    for (int k = 0; k < MAXF && !exp_halt; k++) begin
      exp_fetch.push_back(mpc);
      if (mem[mpc] == HALT_W) begin
        exp_halt = 1'b1;
      end else if (mem[mpc] == MATCH_W) begin
        exp_disp.push_back(mem[mpc]);
        mpc = mpc + 8'd1;
      end else if (st) begin
        exp_halt = 1'b1;
      end else begin
        exp_skips++;
        mpc = mpc + 8'd1;
      end
    end

    do_reset();
    strict = st;
    do_start(sa);
    fi        = 0;
    di        = 0;
    ack_wait  = $urandom_range(0, 2);
    done_wait = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 400; cyc++) begin
      imem_ack  = 1'b0;
      imem_data = 16'($urandom);
      ex_done   = 1'b0;
      if (halted) break;
      if (imem_req && fi >= exp_fetch.size()) break;
      if (imem_req) begin
        if (ack_wait == 0) begin
          check("rnd_fetch_addr", 32'(imem_addr), 32'(exp_fetch[fi]));
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
          fi++;
          ack_wait  = $urandom_range(0, 2);
        end else begin
          ack_wait--;
        end
      end
      if (ex_valid) begin
        if (di < exp_disp.size())
          check("rnd_ex_instr", 32'(ex_instr), 32'(exp_disp[di]));
        if (done_wait == 0) begin
          ex_done   = 1'b1;
          di++;
          done_wait = $urandom_range(0, 3);
        end else begin
          done_wait--;
        end
      end
      tick();
    end
    imem_ack = 1'b0;
    ex_done  = 1'b0;

    check("rnd_fetch_count", 32'(fi), 32'(exp_fetch.size()));
    check("rnd_disp_count",  32'(di), 32'(exp_disp.size()));
    check("rnd_halted",      32'(halted), 32'(exp_halt));
    check("rnd_pc",          32'(pc), 32'(mpc));
`ifdef INSTR_SEQ_STATS_EN
    check("rnd_match_cnt", 32'(match_cnt), 32'(exp_disp.size()));
    check("rnd_skip_cnt",  32'(skip_cnt),  32'(exp_skips));
`endif
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = 8'h00;
    strict     = 1'b0;
    imem_ack   = 1'b0;
    imem_data  = 16'h0;
    ex_done    = 1'b0;

    // Reset, with start asserted at the same time: reset must win.
    tick();
    start      = 1'b1;
    start_addr = 8'h33;
    tick();
    start      = 1'b0;
    check_reset_outputs("reset");
`ifdef INSTR_SEQ_STATS_EN
    check("reset_match_cnt", 32'(match_cnt), 32'(0));
    check("reset_skip_cnt",  32'(skip_cnt),  32'(0));
`endif
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'(0));

    // start -> fetch at start_addr one cycle later.
    do_start(8'h10);
    check("start_req",  32'(imem_req),  32'(1));
    check("start_addr", 32'(imem_addr), 32'(8'h10));
    check("start_busy", 32'(busy),      32'(1));

    // Matching word: ex_valid two cycles after the ack.
    serve(MATCH_W);
    check("decode_valid", 32'(ex_valid), 32'(0));
    check("decode_req",   32'(imem_req), 32'(0));
    tick();
    check("exec_valid", 32'(ex_valid), 32'(1));
    check("exec_instr", 32'(ex_instr), 32'(MATCH_W));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("exec_hold_valid", 32'(ex_valid), 32'(1));
      check("exec_hold_instr", 32'(ex_instr), 32'(MATCH_W));
    end
    pulse_done();
    check("after_done_req",   32'(imem_req),  32'(1));
    check("after_done_addr",  32'(imem_addr), 32'(8'h11));
    check("after_done_valid", 32'(ex_valid),  32'(0));

    // Non-matching word, strict=0: skipped.
    strict = 1'b0;
    serve(16'h1234);
    tick();
    check("skip_req",   32'(imem_req),  32'(1));
    check("skip_addr",  32'(imem_addr), 32'(8'h12));
    check("skip_valid", 32'(ex_valid),  32'(0));

    // Same word with strict=1: halt without advancing the PC.
    strict = 1'b1;
    serve(16'h1234);
    tick();
    check("strict_halted", 32'(halted),   32'(1));
    check("strict_pc",     32'(pc),       32'(8'h12));
    check("strict_req",    32'(imem_req), 32'(0));
    check("strict_busy",   32'(busy),     32'(0));
    start   = 1'b1;
    ex_done = 1'b1;
    tick();
    tick();
    start   = 1'b0;
    ex_done = 1'b0;
    check("halt_sticky",     32'(halted),   32'(1));
    check("halt_sticky_pc",  32'(pc),       32'(8'h12));
    check("halt_sticky_req", 32'(imem_req), 32'(0));

    // Halt pattern halts regardless of strict.
    strict = 1'b0;
    do_reset();
    do_start(8'h20);
    serve(HALT_W);
    tick();
    check("haltpat_halted", 32'(halted), 32'(1));
    check("haltpat_pc",     32'(pc),     32'(8'h20));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("haltpat_start_ignored", 32'(halted), 32'(1));

    // PC wrap from 8'hFF to 8'h00.
    do_reset();
    do_start(8'hFF);
    serve(MATCH_W);
    tick();
    check("wrap_valid", 32'(ex_valid), 32'(1));
    pulse_done();
    check("wrap_addr", 32'(imem_addr), 32'(8'h00));
    check("wrap_pc",   32'(pc),        32'(8'h00));

    // Reset in the middle of EXEC.
    serve(MATCH_W);
    tick();
    check("midexec_valid", 32'(ex_valid), 32'(1));
    rst = 1'b1;
    tick();
    check_reset_outputs("midexec_rst");
    rst = 1'b0;

    // Three dispatches and two skips.
    do_reset();
    strict = 1'b0;
    do_start(8'h40);
    serve(MATCH_W); tick(); pulse_done();
    serve(16'hBEEF); tick();
    serve(MATCH_W); tick(); pulse_done();
    serve(16'h040A); tick();
    serve(MATCH_W); tick(); pulse_done();
    check("stats_seq_addr", 32'(imem_addr), 32'(8'h45));
`ifdef INSTR_SEQ_STATS_EN
    check("stats_match_cnt", 32'(match_cnt), 32'(3));
    check("stats_skip_cnt",  32'(skip_cnt),  32'(2));
`endif

    for (int r = 0; r < 10; r++) random_run();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
